// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA arbiter.
//   dma_state_t   : DMA engine FSM states
//   rd_route_t    : source selected for the next CPU read return
//   dma_src_map() : folds echo-RAM source pages (E0..FF) down by 0x20
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        s_DMA_IDLE  = 2'd0,
        s_DMA_START = 2'd1,
        s_DMA_XFER  = 2'd2
    } dma_state_t;

    typedef enum logic [1:0] {
        ROUTE_MEM = 2'd0,
        ROUTE_HI  = 2'd1,
        ROUTE_REG = 2'd2,
        ROUTE_FF  = 2'd3
    } rd_route_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HI_BASE      = 16'hFF00;
    localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;

    // Pages E0..FF mirror C0..DF, so the transfer really reads 0x20 pages lower.
    function automatic logic [7:0] dma_src_map(input logic [7:0] reg_val);
        if (reg_val < ECHO_BASE_HI) begin
            return reg_val;
        end else begin
            return reg_val - 8'h20;
        end
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: start delay, then a read/latch/write sequence per byte
// copying DMA_LEN bytes from {src_eff, idx} into OAM_BASE + idx.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   trigger           : CPU write to the DMA register; (re)starts a transfer
//   src_reg           : current DMA register value (source page)
//   mem_rdata         : main bus read data, valid the cycle after a read
//   active            : engine owns the main bus
//   bus_read_en/write : main bus strobes requested by the engine
//   bus_addr/wdata    : main bus address and write data requested
module oam_dma_engine
    import oam_dma_arbiter_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LEN         = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [7:0]  src_reg,
    input  logic [7:0]  mem_rdata,
    output logic        active,
    output logic        bus_read_en,
    output logic        bus_write_en,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata
);

    localparam int PW = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0] PH_READ  = PW'(0);
    localparam logic [PW-1:0] PH_LATCH = PW'(1);
    localparam logic [PW-1:0] PH_WRITE = PW'(2);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]    IDX_LAST = 8'(DMA_LEN - 1);

    dma_state_t      state_r;
    logic [PW-1:0]   phase_r;
    logic [7:0]      idx_r;
    logic [7:0]      data_r;

    assign active = (state_r == s_DMA_XFER);

    // FSM, phase/byte counters and the byte data latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= s_DMA_IDLE;
            phase_r <= PW'(0);
            idx_r   <= 8'h00;
            data_r  <= 8'h00;
        end else if (trigger) begin
            // A register write always (re)starts from the start delay.
            state_r <= s_DMA_START;
            phase_r <= PW'(0);
            idx_r   <= 8'h00;
        end else begin
            case (state_r)
                s_DMA_IDLE: begin
                    phase_r <= PW'(0);
                end
                s_DMA_START: begin
                    if (phase_r == PH_LAST) begin
                        state_r <= s_DMA_XFER;
                        phase_r <= PW'(0);
                        idx_r   <= 8'h00;
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                s_DMA_XFER: begin
                    if (phase_r == PH_LATCH) begin
                        data_r <= mem_rdata;
                    end
                    if (phase_r == PH_LAST) begin
                        phase_r <= PW'(0);
                        if (idx_r == IDX_LAST) begin
                            state_r <= s_DMA_IDLE;
                            idx_r   <= 8'h00;
                        end else begin
                            idx_r <= idx_r + 8'd1;
                        end
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                default: begin
                    state_r <= s_DMA_IDLE;
                    phase_r <= PW'(0);
                    idx_r   <= 8'h00;
                end
            endcase
        end
    end

    // Bus request for the current phase; a write coinciding with a restart is dropped.
    always_comb begin
        bus_read_en  = 1'b0;
        bus_write_en = 1'b0;
        bus_addr     = 16'h0000;
        bus_wdata    = 8'h00;
        if (state_r == s_DMA_XFER) begin
            if (phase_r == PH_READ) begin
                bus_read_en = 1'b1;
                bus_addr    = {dma_src_map(src_reg), idx_r};
            end else if (phase_r == PH_WRITE) begin
                bus_write_en = ~trigger;
                bus_addr     = OAM_BASE + {8'h00, idx_r};
                bus_wdata    = data_r;
            end else begin
                bus_read_en = 1'b0;
            end
        end else begin
            bus_read_en = 1'b0;
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU memory bus arbiter with OAM DMA. Holds the DMA register at 0xFF46,
// routes CPU accesses to the main bus (0x0000-0xFEFF) or high bus
// (0xFF00-0xFFFF), and locks the CPU off the main bus during a transfer.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   cpu_addr/wdata/read_en/write_en: CPU request (one-cycle strobes)
//   cpu_rdata                      : read data, valid the cycle after a read
//   mem_*                          : main bus
//   hi_*                           : high bus (IO/HRAM)
//   dma_active                     : transfer currently holds the main bus
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LEN         = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_read_en,
    input  logic        cpu_write_en,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] hi_addr,
    output logic [7:0]  hi_wdata,
    output logic        hi_read_en,
    output logic        hi_write_en,
    input  logic [7:0]  hi_rdata,
    output logic        dma_active
);

    logic [7:0]  dma_reg_r;
    rd_route_t   route_r;

    logic        wr_s;
    logic        rd_s;
    logic        is_reg_s;
    logic        is_hi_s;
    logic        is_main_s;
    logic        trigger_s;

    logic        eng_active_s;
    logic        eng_rd_s;
    logic        eng_wr_s;
    logic [15:0] eng_addr_s;
    logic [7:0]  eng_wdata_s;

    // A write strobe overrides a simultaneous read.
    assign wr_s      = cpu_write_en;
    assign rd_s      = cpu_read_en & ~cpu_write_en;
    assign is_reg_s  = (cpu_addr == DMA_REG_ADDR);
    assign is_hi_s   = (cpu_addr >= HI_BASE) & ~is_reg_s;
    assign is_main_s = (cpu_addr < HI_BASE);
    assign trigger_s = wr_s & is_reg_s;

    assign dma_active = eng_active_s;

    oam_dma_engine #(
        .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
        .DMA_LEN         (DMA_LEN)
    ) u_engine (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger_s),
        .src_reg      (dma_reg_r),
        .mem_rdata    (mem_rdata),
        .active       (eng_active_s),
        .bus_read_en  (eng_rd_s),
        .bus_write_en (eng_wr_s),
        .bus_addr     (eng_addr_s),
        .bus_wdata    (eng_wdata_s)
    );

    // DMA register: loaded by CPU writes to 0xFF46.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_reg_r <= 8'hFF;
        end else if (trigger_s) begin
            dma_reg_r <= cpu_wdata;
        end
    end

    // Read-return route, captured on each CPU read and held until the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_r <= ROUTE_FF;
        end else if (rd_s) begin
            if (is_reg_s) begin
                route_r <= ROUTE_REG;
            end else if (is_hi_s) begin
                route_r <= ROUTE_HI;
            end else if (eng_active_s) begin
                route_r <= ROUTE_FF;
            end else begin
                route_r <= ROUTE_MEM;
            end
        end
    end

    // Read data mux driven by the registered route.
    always_comb begin
        cpu_rdata = 8'hFF;
        case (route_r)
            ROUTE_MEM: cpu_rdata = mem_rdata;
            ROUTE_HI:  cpu_rdata = hi_rdata;
            ROUTE_REG: cpu_rdata = dma_reg_r;
            ROUTE_FF:  cpu_rdata = 8'hFF;
            default:   cpu_rdata = 8'hFF;
        endcase
    end

    // Downstream bus muxing; the engine owns the main bus while active.
    always_comb begin
        mem_addr     = 16'h0000;
        mem_wdata    = 8'h00;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        hi_addr      = 16'h0000;
        hi_wdata     = 8'h00;
        hi_read_en   = 1'b0;
        hi_write_en  = 1'b0;
        if (rst) begin
            mem_read_en = 1'b0;
        end else begin
            if (is_hi_s && (wr_s || rd_s)) begin
                hi_addr     = cpu_addr;
                hi_wdata    = wr_s ? cpu_wdata : 8'h00;
                hi_read_en  = rd_s;
                hi_write_en = wr_s;
            end else begin
                hi_read_en = 1'b0;
            end
            if (eng_active_s) begin
                mem_addr     = eng_addr_s;
                mem_wdata    = eng_wdata_s;
                mem_read_en  = eng_rd_s;
                mem_write_en = eng_wr_s;
            end else if (is_main_s && (wr_s || rd_s)) begin
                mem_addr     = cpu_addr;
                mem_wdata    = wr_s ? cpu_wdata : 8'h00;
                mem_read_en  = rd_s;
                mem_write_en = wr_s;
            end else begin
                mem_read_en = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed self-checking bench for oam_dma_arbiter with main-bus and
// high-bus memory models.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [7:0]  mem_rdata;
    logic [15:0] hi_addr;
    logic [7:0]  hi_wdata;
    logic        hi_read_en;
    logic        hi_write_en;
    logic [7:0]  hi_rdata;
    logic        dma_active;

    logic [7:0] mem  [0:65535];
    logic [7:0] hram [0:255];

    int n_cmp = 0;
    int n_err = 0;

    int act_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int src_err = 0;
    int oam_addr_err = 0;
    int dual_err = 0;
    int hi_ff46_cnt = 0;
    logic [7:0] exp_src = 8'h00;

    oam_dma_arbiter #(.CYCLES_PER_BYTE(4), .DMA_LEN(160)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_read_en  (cpu_read_en),
        .cpu_write_en (cpu_write_en),
        .cpu_rdata    (cpu_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata),
        .hi_addr      (hi_addr),
        .hi_wdata     (hi_wdata),
        .hi_read_en   (hi_read_en),
        .hi_write_en  (hi_write_en),
        .hi_rdata     (hi_rdata),
        .dma_active   (dma_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Bus memory models: write on the strobe edge, read data the next cycle.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= mem[mem_addr];
        if (hi_write_en)  hram[hi_addr[7:0]] <= hi_wdata;
        if (hi_read_en)   hi_rdata <= hram[hi_addr[7:0]];
    end

    // Transfer monitor; a CPU write to FF46 starts a fresh count.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_read_en && mem_write_en) dual_err <= dual_err + 1;
            if ((hi_read_en || hi_write_en) && hi_addr == 16'hFF46) hi_ff46_cnt <= hi_ff46_cnt + 1;
            if (cpu_write_en && cpu_addr == 16'hFF46) begin
                act_cnt <= 0;
                rd_cnt <= 0;
                wr_cnt <= 0;
                src_err <= 0;
                oam_addr_err <= 0;
            end else begin
                if (dma_active) act_cnt <= act_cnt + 1;
                if (dma_active && mem_read_en) begin
                    if (mem_addr != {exp_src, 8'(rd_cnt)}) src_err <= src_err + 1;
                    rd_cnt <= rd_cnt + 1;
                end
                if (dma_active && mem_write_en) begin
                    if (mem_addr != 16'hFE00 + 16'(wr_cnt)) oam_addr_err <= oam_addr_err + 1;
                    wr_cnt <= wr_cnt + 1;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_wdata = d; cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_read_en = 1'b1;
        @(negedge clk);
        cpu_read_en = 1'b0; cpu_addr = 16'h0000;
        d = cpu_rdata;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        bit done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (dma_active) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check_val(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_wr(input int target, input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (wr_cnt == target) found = 1'b1;
        end
        check_val(tag, 64'(found), 64'd1);
    endtask

    task automatic oam_check(input string tag, input logic [7:0] src, input int lo, input int hi);
        int bad = 0;
        for (int i = lo; i < hi; i++) begin
            if (mem[16'hFE00 + 16'(i)] !== pat({src, 8'(i)})) bad++;
        end
        check_val(tag, 64'(bad), 64'd0);
    endtask

    task automatic xfer_counts(input string tag);
        check_val({tag, "_rd"}, 64'(rd_cnt), 64'd160);
        check_val({tag, "_wr"}, 64'(wr_cnt), 64'd160);
        check_val({tag, "_src"}, 64'(src_err), 64'd0);
        check_val({tag, "_oamaddr"}, 64'(oam_addr_err), 64'd0);
    endtask

    logic [60:0] rst_vec_exp;
    assign rst_vec_exp = {5'b0, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'hFF};

    function automatic logic [60:0] out_vec();
        return {dma_active, mem_read_en, mem_write_en, hi_read_en, hi_write_en,
                mem_addr, mem_wdata, hi_addr, hi_wdata, cpu_rdata};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd_v;
        for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
        for (int i = 0; i < 256; i++) hram[i] <= 8'h00;
        mem_rdata <= 8'h00;
        hi_rdata <= 8'h00;
        rst = 1'b1;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", 64'(out_vec()), 64'(rst_vec_exp));
        rst = 1'b0;
        cpu_rd(16'hFF46, rd_v);
        check_val("reg_reset", 64'(rd_v), 64'hFF);

        // Idle CPU access to the main bus, same-cycle strobe.
        @(negedge clk);
        cpu_addr = 16'h1234; cpu_read_en = 1'b1;
        #1;
        check_val("idle_rd_strobe", 64'({mem_read_en, mem_addr, hi_read_en}), 64'({1'b1, 16'h1234, 1'b0}));
        @(negedge clk);
        cpu_read_en = 1'b0; cpu_addr = 16'h0000;
        check_val("idle_rd_data", 64'(cpu_rdata), 64'(pat(16'h1234)));
        cpu_wr(16'h2345, 8'h99);
        cpu_rd(16'h2345, rd_v);
        check_val("idle_wr_rd", 64'(rd_v), 64'h99);

        // Transfer from C1 with CPU traffic during the lockout.
        exp_src = 8'hC1;
        cpu_wr(16'hFF46, 8'hC1);
        check_val("start_d0", 64'(dma_active), 64'd0);
        repeat (3) @(negedge clk);
        check_val("start_d3", 64'(dma_active), 64'd0);
        @(negedge clk);
        check_val("active_rise", 64'(dma_active), 64'd1);
        cpu_rd(16'hC000, rd_v);
        check_val("lock_rd", 64'(rd_v), 64'hFF);
        cpu_wr(16'hD000, 8'h55);
        cpu_wr(16'hFF80, 8'hAA);
        cpu_rd(16'hFF80, rd_v);
        check_val("hram_rd", 64'(rd_v), 64'hAA);
        cpu_rd(16'hFF46, rd_v);
        check_val("reg_rd_busy", 64'(rd_v), 64'hC1);
        wait_done("c1_done");
        check_val("c1_active_cyc", 64'(act_cnt), 64'd640);
        xfer_counts("c1");
        oam_check("c1_oam", 8'hC1, 0, 160);
        check_val("lock_wr_dropped", 64'(mem[16'hD000]), 64'(pat(16'hD000)));
        cpu_rd(16'hFF46, rd_v);
        check_val("c1_reg", 64'(rd_v), 64'hC1);

        // Echo-RAM source page.
        exp_src = 8'hDE;
        cpu_wr(16'hFF46, 8'hFE);
        wait_done("fe_done");
        xfer_counts("fe");
        oam_check("fe_oam", 8'hDE, 0, 160);
        cpu_rd(16'hFF46, rd_v);
        check_val("fe_reg", 64'(rd_v), 64'hFE);

        // Restart after 50 bytes.
        exp_src = 8'hC0;
        cpu_wr(16'hFF46, 8'hC0);
        wait_wr(50, "c0_50");
        exp_src = 8'hD0;
        cpu_wr(16'hFF46, 8'hD0);
        wait_done("d0_done");
        xfer_counts("d0");
        oam_check("d0_oam", 8'hD0, 0, 160);

        // Reset at byte 80.
        exp_src = 8'hC1;
        cpu_wr(16'hFF46, 8'hC1);
        wait_wr(80, "c1b_80");
        rst = 1'b1;
        #1;
        check_val("midrst_outputs", 64'(out_vec()), 64'(rst_vec_exp));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        oam_check("midrst_oam_lo", 8'hC1, 0, 80);
        oam_check("midrst_oam_hi", 8'hD0, 80, 160);
        cpu_rd(16'hFF46, rd_v);
        check_val("midrst_reg", 64'(rd_v), 64'hFF);
        repeat (8) @(negedge clk);
        check_val("midrst_idle", 64'(dma_active), 64'd0);
        exp_src = 8'hC2;
        cpu_wr(16'hFF46, 8'hC2);
        wait_done("c2_done");
        xfer_counts("c2");
        oam_check("c2_oam", 8'hC2, 0, 160);

        // Simultaneous read+write to FF46: write only, read route held.
        cpu_rd(16'h1234, rd_v);
        check_val("pre_rw_rd", 64'(rd_v), 64'(pat(16'h1234)));
        exp_src = 8'h77;
        @(negedge clk);
        cpu_addr = 16'hFF46; cpu_wdata = 8'h77;
        cpu_read_en = 1'b1; cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_read_en = 1'b0; cpu_write_en = 1'b0;
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        check_val("rw_route_hold", 64'(cpu_rdata), 64'(pat(16'h1234)));
        wait_done("rw_done");
        xfer_counts("rw");
        oam_check("rw_oam", 8'h77, 0, 160);
        cpu_rd(16'hFF46, rd_v);
        check_val("rw_reg", 64'(rd_v), 64'h77);

        check_val("dual_strobe", 64'(dual_err), 64'd0);
        check_val("ff46_on_hi_bus", 64'(hi_ff46_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
